// File: rtl/frobenius_norm_seq.sv
// Sequential Frobenius norm: streams a SIZE_A x SIZE_B matrix from synchronous RAM,
// accumulates squares, and hands the sum to a shared squareroot core.
// Optional threshold compare is built when FROB_NORM_THRESH_EN is defined.
module frobenius_norm_seq #(
    parameter int SIZE_A  = 8,
    parameter int SIZE_B  = 8,
    parameter int N_BITS  = 32,
    parameter int WIDTH_B = 7,
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 clear,
    output logic                                 rd_en,
    output logic [ROW_W-1:0]                     rd_row,
    output logic [COL_W-1:0]                     rd_col,
    input  logic signed [N_BITS-1:0]             rd_data,
    output logic                                 sq_start,
    output logic [2*N_BITS+WIDTH_B-1:0]          sq_number,
    input  logic [(2*N_BITS+WIDTH_B)/2:0]        sq_result,
    input  logic                                 sq_valid,
`ifdef FROB_NORM_THRESH_EN
    input  logic [(2*N_BITS+WIDTH_B)/2:0]        thresh,
    output logic                                 converged,
`endif
    output logic [(2*N_BITS+WIDTH_B)/2:0]        norm,
    output logic                                 busy,
    output logic                                 done
);

    localparam int ACC_W = 2*N_BITS + WIDTH_B;
    localparam int SQ_W  = 2*N_BITS;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE_A-1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SIZE_B-1);

    typedef enum logic [2:0] {
        IDLE, READ, DRAIN, SQ_START, SQ_WAIT, DONE
    } state_t;

    state_t state, state_d;

    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic                    rd_en_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [SQ_W-1:0]  din_ext;
    logic signed [SQ_W-1:0]  sq;
    logic                    last_addr;

    assign last_addr = (row == LAST_ROW) && (col == LAST_COL);

    // Squares are never negative, so the signed extension into acc is always a plain add.
    assign din_ext  = SQ_W'(rd_data);
    assign sq       = din_ext * din_ext;
    assign acc_next = rd_en_q ? acc + ACC_W'(sq) : acc;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     if (start) state_d = READ;
            READ:     if (last_addr) state_d = DRAIN;
            DRAIN:    state_d = SQ_START;
            SQ_START: state_d = SQ_WAIT;
            SQ_WAIT:  if (sq_valid) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    assign rd_en    = (state == READ);
    assign rd_row   = row;
    assign rd_col   = col;
    assign sq_start = (state == SQ_START);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            rd_en_q   <= 1'b0;
            acc       <= '0;
            sq_number <= '0;
            norm      <= '0;
        end else if (clear) begin
            // Abort drops any in-flight read data; norm keeps the last good result.
            row     <= '0;
            col     <= '0;
            rd_en_q <= 1'b0;
            acc     <= '0;
        end else begin
            rd_en_q <= (state == READ);
            if (state == IDLE) begin
                row <= '0;
                col <= '0;
                acc <= '0;
            end else begin
                acc <= acc_next;
            end

            if (state == READ) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            // Load the radicand as the last element lands so it is valid alongside sq_start.
            if (state == DRAIN) sq_number <= acc_next;

            if (state == SQ_WAIT && sq_valid) norm <= sq_result;
        end
    end

`ifdef FROB_NORM_THRESH_EN
    logic [(2*N_BITS+WIDTH_B)/2:0] thresh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q  <= '0;
            converged <= 1'b0;
        end else if (clear) begin
            converged <= 1'b0;
        end else begin
            if (state == IDLE && start) thresh_q <= thresh;
            if (state == DONE) converged <= (norm < thresh_q);
        end
    end
`endif

endmodule
